// File: rtl/uart_core.sv
// uart_core: single-clock UART with TX and RX engines and 3-sample majority voting on RX.
// Optional feature: define UART_LOOPBACK_EN to add the LOOPBACK input (TX stream fed to RX, TX_OUT held high).
module uart_core #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DIV_WIDTH-1:0]  BAUD_DIV,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic                  Data_Valid_TX,
  input  logic [DATA_WIDTH-1:0] P_DATA_TX,
  output logic                  TX_OUT,
  output logic                  Busy,
  input  logic                  RX_IN,
`ifdef UART_LOOPBACK_EN
  input  logic                  LOOPBACK,
`endif
  output logic                  data_valid_RX,
  output logic [DATA_WIDTH-1:0] P_DATA_RX,
  output logic                  Parity_error,
  output logic                  Framing_error
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] TICK_S0   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] TICK_S1   = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] TICK_S2   = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Tick generators: index 0 serves TX, index 1 serves RX; each restarts at its frame start
  // so every bit lasts exactly OVERSAMPLE*(BAUD_DIV+1) clocks.
  logic [1:0] tick;
  logic [1:0] restart;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_prescale
      logic [DIV_WIDTH-1:0] cnt_reg;
      always_ff @(posedge CLK) begin
        if (RST || restart[gi] || cnt_reg >= BAUD_DIV)
          cnt_reg <= '0;
        else
          cnt_reg <= cnt_reg + DIV_WIDTH'(1);
      end
      assign tick[gi] = (cnt_reg >= BAUD_DIV);
    end
  endgenerate

  // ---------------- TX ----------------
  state_t                tx_state_reg, tx_state_next;
  logic [DATA_WIDTH-1:0] tx_data_reg;
  logic [CW-1:0]         tx_tick_reg;
  logic [BW-1:0]         tx_bit_reg;
  logic                  tx_par_en_reg, tx_par_typ_reg, tx_stop2_reg;
  logic                  tx_accept, tx_bit_end, tx_line;

  assign tx_accept  = (tx_state_reg == S_IDLE) && Data_Valid_TX;
  assign tx_bit_end = tick[0] && (tx_tick_reg == TICK_LAST);
  assign restart[0] = tx_accept;

  always_ff @(posedge CLK) begin
    if (RST)
      tx_state_reg <= S_IDLE;
    else
      tx_state_reg <= tx_state_next;
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    case (tx_state_reg)
      S_IDLE:   if (tx_accept) tx_state_next = S_START;
      S_START:  if (tx_bit_end) tx_state_next = S_DATA;
      S_DATA:   if (tx_bit_end && tx_bit_reg == BIT_LAST)
                  tx_state_next = tx_par_en_reg ? S_PARITY : S_STOP;
      S_PARITY: if (tx_bit_end) tx_state_next = S_STOP;
      S_STOP:   if (tx_bit_end && (!tx_stop2_reg || tx_bit_reg != '0))
                  tx_state_next = S_IDLE;
      default:  tx_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    Busy    = (tx_state_reg != S_IDLE);
    tx_line = 1'b1;
    case (tx_state_reg)
      S_START:  tx_line = 1'b0;
      S_DATA:   tx_line = tx_data_reg[tx_bit_reg];
      S_PARITY: tx_line = ^tx_data_reg ^ tx_par_typ_reg;
      default:  tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_data_reg    <= '0;
      tx_tick_reg    <= '0;
      tx_bit_reg     <= '0;
      tx_par_en_reg  <= 1'b0;
      tx_par_typ_reg <= 1'b0;
      tx_stop2_reg   <= 1'b0;
    end else begin
      if (tx_accept) begin
        tx_data_reg    <= P_DATA_TX;
        tx_par_en_reg  <= PAR_EN;
        tx_par_typ_reg <= PAR_TYP;
        tx_stop2_reg   <= STOP2;
      end
      if (tx_state_reg == S_IDLE)
        tx_tick_reg <= '0;
      else if (tick[0])
        tx_tick_reg <= tx_tick_reg + CW'(1);
      // Bit index doubles as the stop-bit counter; it restarts on every state change.
      if (tx_state_next != tx_state_reg)
        tx_bit_reg <= '0;
      else if (tx_bit_end)
        tx_bit_reg <= tx_bit_reg + BW'(1);
    end
  end

  // ---------------- RX ----------------
  logic rx_sync1_reg, rx_sync2_reg, rx_prev_reg, rx_line;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_sync1_reg <= 1'b1;
      rx_sync2_reg <= 1'b1;
      rx_prev_reg  <= 1'b1;
    end else begin
      rx_sync1_reg <= RX_IN;
      rx_sync2_reg <= rx_sync1_reg;
      rx_prev_reg  <= rx_line;
    end
  end

`ifdef UART_LOOPBACK_EN
  assign rx_line = LOOPBACK ? tx_line : rx_sync2_reg;
  assign TX_OUT  = LOOPBACK ? 1'b1 : tx_line;
`else
  assign rx_line = rx_sync2_reg;
  assign TX_OUT  = tx_line;
`endif

  state_t                rx_state_reg, rx_state_next;
  logic [CW-1:0]         rx_tick_reg;
  logic [BW-1:0]         rx_bit_reg;
  logic [1:0]            rx_samp_reg;
  logic [DATA_WIDTH-1:0] rx_shift_reg, rx_data_reg;
  logic                  rx_par_bit_reg, rx_par_en_reg, rx_par_typ_reg;
  logic                  rx_valid_reg, rx_perr_reg, rx_ferr_reg;
  logic                  rx_start, rx_bit_end, rx_mid, rx_vote;
  logic                  rx_stop_check, rx_par_err, rx_frame_err;

  assign rx_start   = (rx_state_reg == S_IDLE) && rx_prev_reg && !rx_line;
  assign restart[1] = rx_start;
  assign rx_bit_end = tick[1] && (rx_tick_reg == TICK_LAST);
  assign rx_mid     = tick[1] && (rx_tick_reg == TICK_S2);
  // Third sample is taken live; the first two were captured at the preceding ticks.
  assign rx_vote    = (rx_samp_reg[1] & rx_samp_reg[0]) | (rx_samp_reg[1] & rx_line)
                    | (rx_samp_reg[0] & rx_line);

  always_ff @(posedge CLK) begin
    if (RST)
      rx_state_reg <= S_IDLE;
    else
      rx_state_reg <= rx_state_next;
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    case (rx_state_reg)
      S_IDLE:   if (rx_start) rx_state_next = S_START;
      S_START:  if (rx_mid && rx_vote) rx_state_next = S_IDLE;
                else if (rx_bit_end) rx_state_next = S_DATA;
      S_DATA:   if (rx_bit_end && rx_bit_reg == BIT_LAST)
                  rx_state_next = rx_par_en_reg ? S_PARITY : S_STOP;
      S_PARITY: if (rx_bit_end) rx_state_next = S_STOP;
      S_STOP:   if (rx_mid) rx_state_next = S_IDLE;
      default:  rx_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_stop_check = (rx_state_reg == S_STOP) && rx_mid;
    rx_par_err    = rx_stop_check && rx_par_en_reg
                  && (rx_par_bit_reg != (^rx_shift_reg ^ rx_par_typ_reg));
    rx_frame_err  = rx_stop_check && !rx_vote;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_tick_reg    <= '0;
      rx_bit_reg     <= '0;
      rx_samp_reg    <= 2'b11;
      rx_shift_reg   <= '0;
      rx_data_reg    <= '0;
      rx_par_bit_reg <= 1'b0;
      rx_par_en_reg  <= 1'b0;
      rx_par_typ_reg <= 1'b0;
      rx_valid_reg   <= 1'b0;
      rx_perr_reg    <= 1'b0;
      rx_ferr_reg    <= 1'b0;
    end else begin
      if (rx_start) begin
        rx_par_en_reg  <= PAR_EN;
        rx_par_typ_reg <= PAR_TYP;
      end
      if (rx_state_reg == S_IDLE)
        rx_tick_reg <= '0;
      else if (tick[1])
        rx_tick_reg <= rx_tick_reg + CW'(1);
      if (rx_state_next != rx_state_reg)
        rx_bit_reg <= '0;
      else if (rx_bit_end)
        rx_bit_reg <= rx_bit_reg + BW'(1);
      if (rx_state_reg != S_IDLE && tick[1] && (rx_tick_reg == TICK_S0 || rx_tick_reg == TICK_S1))
        rx_samp_reg <= {rx_samp_reg[0], rx_line};
      if (rx_mid && rx_state_reg == S_DATA)
        rx_shift_reg <= {rx_vote, rx_shift_reg[DATA_WIDTH-1:1]};
      if (rx_mid && rx_state_reg == S_PARITY)
        rx_par_bit_reg <= rx_vote;
      rx_valid_reg <= rx_stop_check && !rx_par_err && !rx_frame_err;
      rx_perr_reg  <= rx_par_err;
      rx_ferr_reg  <= rx_frame_err;
      if (rx_stop_check && !rx_par_err && !rx_frame_err)
        rx_data_reg <= rx_shift_reg;
    end
  end

  assign data_valid_RX = rx_valid_reg;
  assign P_DATA_RX     = rx_data_reg;
  assign Parity_error  = rx_perr_reg;
  assign Framing_error = rx_ferr_reg;

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: randomized scoreboard bench for uart_core (DATA_WIDTH=8, OVERSAMPLE=8, BAUD_DIV=1).
// TX line and RX pulses are checked by independent monitors against queued expectations.
module tb_uart_core;
  localparam int BIT_CLKS = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] BAUD_DIV = 16'd1;
  logic        PAR_EN = 1'b0, PAR_TYP = 1'b0, STOP2 = 1'b0, Data_Valid_TX = 1'b0;
  logic [7:0]  P_DATA_TX = 8'h00;
  logic        TX_OUT, Busy, data_valid_RX, Parity_error, Framing_error;
  logic [7:0]  P_DATA_RX;
  logic        rx_bb = 1'b1, loop_sel = 1'b0;
  logic        RX_IN;
`ifdef UART_LOOPBACK_EN
  logic        LOOPBACK = 1'b0;
`endif

  assign RX_IN = loop_sel ? TX_OUT : rx_bb;

  uart_core #(.DATA_WIDTH(8), .OVERSAMPLE(8), .DIV_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .BAUD_DIV(BAUD_DIV), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .STOP2(STOP2), .Data_Valid_TX(Data_Valid_TX), .P_DATA_TX(P_DATA_TX), .TX_OUT(TX_OUT),
    .Busy(Busy), .RX_IN(RX_IN),
`ifdef UART_LOOPBACK_EN
    .LOOPBACK(LOOPBACK),
`endif
    .data_valid_RX(data_valid_RX), .P_DATA_RX(P_DATA_RX),
    .Parity_error(Parity_error), .Framing_error(Framing_error)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [7:0] data; bit pe; bit typ; bit s2; } tx_exp_t;
  typedef struct { bit valid; bit perr; bit ferr; logic [7:0] pdata; } rx_exp_t;

  tx_exp_t    tx_q[$];
  rx_exp_t    rx_q[$];
  logic [7:0] rx_held = 8'h00;
  bit         lb_mode = 1'b0;
  int         checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional parity, one or two stop bits.
  function automatic int frame_bits(input tx_exp_t e, output logic [11:0] bits);
    int n;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[4'(1 + i)] = e.data[3'(i)];
    n = 9;
    if (e.pe) begin
      bits[4'(n)] = 1'(($countones(e.data) % 2) ^ int'(e.typ));
      n++;
    end
    bits[4'(n)] = 1'b1;
    n++;
    if (e.s2) n++;
    return n;
  endfunction

  task automatic push_rx(input logic [7:0] data, input bit perr, input bit ferr);
    rx_exp_t r;
    r.perr  = perr;
    r.ferr  = ferr;
    r.valid = !(perr || ferr);
    if (r.valid) rx_held = data;
    r.pdata = rx_held;
    rx_q.push_back(r);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_tx(input logic [7:0] data, input bit pe, input bit typ, input bit s2);
    tx_exp_t e;
    int guard = 0;
    while (Busy && guard < 1000) begin
      step();
      guard++;
    end
    if (Busy) begin
      checks++;
      errors++;
      $display("FAIL tx_wait_idle_timeout busy=%0b required=0", Busy);
      return;
    end
    PAR_EN = pe; PAR_TYP = typ; STOP2 = s2; P_DATA_TX = data; Data_Valid_TX = 1'b1;
    e.data = data; e.pe = pe; e.typ = typ; e.s2 = s2;
    if (!lb_mode) tx_q.push_back(e);
    if (loop_sel || lb_mode) push_rx(data, 1'b0, 1'b0);
    step();
    Data_Valid_TX = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] data, input bit pe, input bit typ,
                         input bit flip, input bit bad_stop);
    logic [11:0] bits;
    int n;
    PAR_EN = pe; PAR_TYP = typ;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[4'(1 + i)] = data[3'(i)];
    n = 9;
    if (pe) begin
      bits[4'(n)] = 1'(($countones(data) % 2) ^ int'(typ) ^ int'(flip));
      n++;
    end
    bits[4'(n)] = !bad_stop;
    n++;
    push_rx(data, pe && flip, bad_stop);
    for (int i = 0; i < n; i++) begin
      rx_bb = bits[4'(i)];
      repeat (BIT_CLKS) step();
    end
    rx_bb = 1'b1;
    repeat ($urandom_range(2, 20)) step();
  endtask

  // TX monitor: samples mid-bit while Busy and scores the frame when Busy drops.
  int          tx_cyc = 0, tx_ns = 0, tx_n;
  bit          tx_act = 1'b0, lb_bad = 1'b0;
  logic [11:0] tx_samp = '1, tx_bits;
  tx_exp_t     tx_e;

  always @(negedge CLK) begin
    if (RST) begin
      tx_act = 1'b0;
      tx_q.delete();
    end else if (Busy) begin
      if (!tx_act) begin
        tx_act = 1'b1; tx_cyc = 0; tx_ns = 0; tx_samp = '1; lb_bad = 1'b0;
      end
      if (tx_cyc % BIT_CLKS == BIT_CLKS / 2 && tx_ns < 12) begin
        tx_samp[4'(tx_ns)] = TX_OUT;
        tx_ns++;
      end
      if (lb_mode && TX_OUT !== 1'b1) lb_bad = 1'b1;
      tx_cyc++;
    end else if (tx_act) begin
      tx_act = 1'b0;
      if (lb_mode) begin
        check("lb_tx_out_high", 32'(lb_bad), 32'd0);
      end else if (tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected_frame busy_cycles=%0d required=none", tx_cyc);
      end else begin
        tx_e = tx_q.pop_front();
        tx_n = frame_bits(tx_e, tx_bits);
        check("tx_busy_cycles", tx_cyc, tx_n * BIT_CLKS);
        check("tx_line_bits", 32'(tx_samp), 32'(tx_bits));
        check("tx_idle_high", 32'(TX_OUT), 32'd1);
      end
    end
  end

  // RX monitor: every pulse must match the next queued expectation.
  rx_exp_t rx_e;

  always @(negedge CLK) begin
    if (!RST && (data_valid_RX || Parity_error || Framing_error)) begin
      if (rx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected_event valid=%0b perr=%0b ferr=%0b data=%0h required=none",
                 data_valid_RX, Parity_error, Framing_error, P_DATA_RX);
      end else begin
        rx_e = rx_q.pop_front();
        check("rx_valid", 32'(data_valid_RX), 32'(rx_e.valid));
        check("rx_parity_err", 32'(Parity_error), 32'(rx_e.perr));
        check("rx_framing_err", 32'(Framing_error), 32'(rx_e.ferr));
        check("rx_data", 32'(P_DATA_RX), 32'(rx_e.pdata));
      end
    end
  end

  task automatic drain();
    int guard = 0;
    while ((tx_q.size() != 0 || rx_q.size() != 0 || Busy) && guard < 3000) begin
      step();
      guard++;
    end
    repeat (20) step();
    check("tx_queue_drained", tx_q.size(), 0);
    check("rx_queue_drained", rx_q.size(), 0);
  endtask

  initial begin
    logic [7:0] d;
    bit pe, typ, s2;

    repeat (3) step();
    RST = 1'b0;
    step();
    check("reset_tx_out", 32'(TX_OUT), 32'd1);
    check("reset_busy", 32'(Busy), 32'd0);

    // Reset in the middle of a TX frame
    send_tx(8'h96, 1'b1, 1'b0, 1'b0);
    repeat (40) step();
    RST = 1'b1;
    step();
    check("midreset_tx_out", 32'(TX_OUT), 32'd1);
    check("midreset_busy", 32'(Busy), 32'd0);
    step();
    RST = 1'b0;
    step();
    check("midreset_p_data_rx", 32'(P_DATA_RX), 32'h00);
    check("midreset_pulses", 32'({data_valid_RX, Parity_error, Framing_error}), 32'd0);

    // Directed TX (line looped to RX), ignored mid-frame request, back-to-back frame
    loop_sel = 1'b1;
    send_tx(8'hA5, 1'b1, 1'b0, 1'b0);
    repeat (60) step();
    P_DATA_TX = 8'hFF;
    Data_Valid_TX = 1'b1;
    step();
    Data_Valid_TX = 1'b0;
    send_tx(8'h5A, 1'b1, 1'b1, 1'b1);
    drain();
    loop_sel = 1'b0;

    // Directed RX: good, parity error, framing error, recovery, both errors, false start
    send_rx(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    send_rx(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
    send_rx(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    send_rx(8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
    send_rx(8'hE7, 1'b1, 1'b0, 1'b1, 1'b1);
    rx_bb = 1'b0;
    repeat (3) step();
    rx_bb = 1'b1;
    repeat (40) step();
    send_rx(8'hA7, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    // Random TX with configuration scrambled after acceptance
    for (int k = 0; k < 5; k++) begin
      d = 8'($urandom); pe = 1'($urandom); typ = 1'($urandom); s2 = 1'($urandom);
      send_tx(d, pe, typ, s2);
      PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom); STOP2 = 1'($urandom);
      P_DATA_TX = 8'($urandom);
    end
    drain();

    // Random RX frames with random error injection
    for (int k = 0; k < 10; k++) begin
      d = 8'($urandom); pe = 1'($urandom); typ = 1'($urandom);
      send_rx(d, pe, typ, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end
    drain();

    // Random TX looped into RX
    loop_sel = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom); pe = 1'($urandom); typ = 1'($urandom); s2 = 1'($urandom);
      send_tx(d, pe, typ, s2);
    end
    drain();
    loop_sel = 1'b0;

`ifdef UART_LOOPBACK_EN
    lb_mode = 1'b1;
    LOOPBACK = 1'b1;
    send_tx(8'hC3, 1'b1, 1'b0, 1'b0);
    drain();
    check("lb_p_data_rx", 32'(P_DATA_RX), 32'hC3);
    LOOPBACK = 1'b0;
    repeat (5) step();
    lb_mode = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
